// File: rtl/key_capture_slave_if.sv
// ----------------------------------------------------------------------------
// key_capture_slave_if
// Avalon-MM bus between the processor data master and the key capture slave.
//   avs_address       word address (0 DATA, 1 IRQ_MASK, 2 EDGE, 3 COUNT)
//   avs_read          single-cycle read strobe
//   avs_write         single-cycle write strobe
//   avs_writedata     write data
//   avs_readdata      read data, valid while avs_readdatavalid is high
//   avs_readdatavalid one-cycle pulse, exactly one clock after avs_read
// ----------------------------------------------------------------------------
interface key_capture_slave_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/key_capture_slave.sv
// ----------------------------------------------------------------------------
// key_capture_slave
// Avalon-MM responder giving debounced access to active-low push-buttons.
// Synchronises and debounces the keys, latches press events in a sticky
// RW1C edge register, counts presses (saturating) and drives a maskable irq.
//   clk_0    system clock
//   reset    synchronous, active-high reset
//   keys_in  raw key pins, active-low, asynchronous
//   avs      Avalon-MM slave port (see key_capture_slave_if)
//   irq      level interrupt, active-high: |(edge & mask), registered
// ----------------------------------------------------------------------------
module key_capture_slave #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk_0,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    key_capture_slave_if.slave  avs,
    output logic                irq
);

    // Sync flops hold the raw pin polarity so the all-1 reset value means
    // "released"; inversion to pressed=1 happens after the second flop.
    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_mask;
    logic [NUM_KEYS-1:0] r_edge;
    logic [7:0]          r_count;
    logic [31:0]         r_rdata;
    logic                r_rdv;
    logic                r_irq;

    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] w_accept;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_edge_clr;
    logic [3:0]          w_popcnt;
    logic [9:0]          w_cnt_sum;
    logic [7:0]          w_cnt_base;
    logic [31:0]         w_rdata;
    logic                w_wr_mask, w_wr_edge, w_wr_count;
    logic                w_unused_wdata;

    assign w_pressed = ~r_sync2;

    always_ff @(posedge clk_0) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= keys_in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce counter: counts consecutive cycles the synchronised
    // level disagrees with the accepted level; any agreement restarts it.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_db
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;

        assign w_diff      = w_pressed[g] ^ r_stable[g];
        assign w_accept[g] = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

        always_ff @(posedge clk_0) begin
            if (reset || !w_diff || w_accept[g])
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Accept only happens when the levels differ, so it is a toggle.
    assign w_press = w_accept & w_pressed;

    assign w_wr_mask  = avs.avs_write && (avs.avs_address == 2'd1);
    assign w_wr_edge  = avs.avs_write && (avs.avs_address == 2'd2);
    assign w_wr_count = avs.avs_write && (avs.avs_address == 2'd3);
    assign w_edge_clr = w_wr_edge ? avs.avs_writedata[NUM_KEYS-1:0] : '0;

    assign w_unused_wdata = &{1'b0, avs.avs_writedata};

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            w_popcnt = w_popcnt + {3'b000, w_press[i]};
    end

    // A COUNT write clears first, then this cycle's events are added.
    assign w_cnt_base = w_wr_count ? 8'd0 : r_count;
    assign w_cnt_sum  = {2'b00, w_cnt_base} + {6'd0, w_popcnt};

    always_comb begin
        w_rdata = '0;
        case (avs.avs_address)
            2'd0: w_rdata[NUM_KEYS-1:0] = r_stable;
            2'd1: w_rdata[NUM_KEYS-1:0] = r_mask;
            2'd2: w_rdata[NUM_KEYS-1:0] = r_edge;
            2'd3: w_rdata[7:0]          = r_count;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (reset) begin
            r_stable <= '0;
            r_mask   <= '0;
            r_edge   <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_rdv    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_stable <= r_stable ^ w_accept;
            if (w_wr_mask)
                r_mask <= avs.avs_writedata[NUM_KEYS-1:0];
            // Set after clear: a press in the same cycle as its RW1C wins.
            r_edge  <= (r_edge & ~w_edge_clr) | w_press;
            r_count <= (w_cnt_sum > 10'd255) ? 8'd255 : w_cnt_sum[7:0];
            if (avs.avs_read)
                r_rdata <= w_rdata;
            r_rdv <= avs.avs_read;
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign avs.avs_readdata      = r_rdata;
    assign avs.avs_readdatavalid = r_rdv;
    assign irq                   = r_irq;

endmodule
